// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        DESLOCA,
        PRONTO
    } estado_e;

    localparam logic [3:0] LIMIAR_AJUSTE = 4'd5;
    localparam logic [3:0] SOMA_AJUSTE   = 4'd3;

    // Decimal digits needed to show 2^largura - 1, i.e. ceil(largura * log10 2).
    function automatic int unsigned digitos_min(input int unsigned largura);
        logic [63:0] maximo;
        int unsigned n;
        maximo = (64'd1 << largura) - 64'd1;
        n      = 0;
        for (int i = 0; i < 20; i++) begin
            if (maximo != 64'd0) begin
                n      = n + 1;
                maximo = maximo / 64'd10;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ajuste_digito_bcd.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module ajuste_digito_bcd
    import bcd_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);

    assign digito_o = (digito_i >= LIMIAR_AJUSTE) ? digito_i + SOMA_AJUSTE : digito_i;

endmodule

// File: rtl/binario_para_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, with
// ready/valid on both sides, optional signed input and leading-zero mask.
module binario_para_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned LARGURA = 16,
    parameter int unsigned DIGITOS = 5,
    parameter bit          SINAL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LARGURA-1:0]     binario,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   negativo,
    output logic [DIGITOS-1:0]     mascara,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned CW = $clog2(LARGURA + 1);
    localparam int unsigned BW = 4 * DIGITOS;

    if (LARGURA < 2 || LARGURA > 32) begin : g_err_largura
        $error("binario_para_bcd_seq: LARGURA must be in 2..32");
    end
    if (DIGITOS < digitos_min(LARGURA)) begin : g_err_digitos
        $error("binario_para_bcd_seq: DIGITOS too small for LARGURA");
    end

    estado_e              estado_q, estado_d;
    logic [CW-1:0]        cont_q, cont_d;
    logic [LARGURA-1:0]   oper_q, oper_d;
    logic [BW-1:0]        acum_q, acum_d;
    logic                 neg_q, neg_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic                 negativo_q, negativo_d;
    logic [DIGITOS-1:0]   mascara_q, mascara_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;

    logic [BW-1:0]        acum_aj;
    logic [BW-1:0]        acum_desl;
    logic [DIGITOS-1:0]   mascara_nova;
    logic                 msb_descarte_unused;
    logic                 ultima_iter;

    for (genvar k = 0; k < DIGITOS; k++) begin : g_ajuste
        ajuste_digito_bcd u_ajuste (
            .digito_i(acum_q[4*k +: 4]),
            .digito_o(acum_aj[4*k +: 4])
        );
    end

    // The top accumulator bit is shifted out; DIGITOS guarantees it is always 0.
    assign msb_descarte_unused = acum_aj[BW-1];
    assign acum_desl           = {acum_aj[BW-2:0], oper_q[LARGURA-1]};
    assign ultima_iter         = (cont_q == CW'(1));

    always_comb begin
        logic signif;
        signif       = 1'b0;
        mascara_nova = '0;
        for (int k = int'(DIGITOS) - 1; k >= 0; k--) begin
            signif          = signif | (acum_desl[4*k +: 4] != 4'd0);
            mascara_nova[k] = signif;
        end
        mascara_nova[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q    <= OCIOSO;
            cont_q      <= '0;
            oper_q      <= '0;
            acum_q      <= '0;
            neg_q       <= 1'b0;
            bcd_q       <= '0;
            negativo_q  <= 1'b0;
            mascara_q   <= DIGITOS'(1);
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            oper_q      <= oper_d;
            acum_q      <= acum_d;
            neg_q       <= neg_d;
            bcd_q       <= bcd_d;
            negativo_q  <= negativo_d;
            mascara_q   <= mascara_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (in_valid && in_ready_q) estado_d = DESLOCA;
            DESLOCA: if (ultima_iter) estado_d = PRONTO;
            PRONTO:  if (out_ready && out_valid_q) estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        cont_d     = cont_q;
        oper_d     = oper_q;
        acum_d     = acum_q;
        neg_d      = neg_q;
        bcd_d      = bcd_q;
        negativo_d = negativo_q;
        mascara_d  = mascara_q;
        case (estado_q)
            OCIOSO: begin
                if (in_valid && in_ready_q) begin
                    cont_d = CW'(LARGURA);
                    acum_d = '0;
                    if (SINAL && binario[LARGURA-1]) begin
                        oper_d = -binario;
                        neg_d  = 1'b1;
                    end else begin
                        oper_d = binario;
                        neg_d  = 1'b0;
                    end
                end
            end
            DESLOCA: begin
                cont_d = cont_q - CW'(1);
                acum_d = acum_desl;
                oper_d = {oper_q[LARGURA-2:0], 1'b0};
                if (ultima_iter) begin
                    bcd_d      = acum_desl;
                    negativo_d = neg_q;
                    mascara_d  = mascara_nova;
                end
            end
            default: ;
        endcase
        in_ready_d  = (estado_d == OCIOSO);
        out_valid_d = (estado_d == PRONTO);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign negativo  = negativo_q;
    assign mascara   = mascara_q;

endmodule

// File: tb/tb_binario_para_bcd_seq.sv
// Bench for binario_para_bcd_seq: four parameter sets, directed cases plus a
// random sweep checked against a decimal reference model.
module tb_binario_para_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] bin_all;
    logic        iv_all;
    logic        or_all;
    int          sel;

    int n_checks = 0;
    int n_fail   = 0;

    // Configurations: 0 = 16/5/unsigned, 1 = 8/3/signed, 2 = 4/2/unsigned, 3 = 32/10/unsigned
    int larg [4] = '{16, 8, 4, 32};
    int dig  [4] = '{5, 3, 2, 10};
    bit sin  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    logic iv0, ir0, neg0, ov0; logic [19:0] bcd0; logic [4:0] m0;
    logic iv1, ir1, neg1, ov1; logic [11:0] bcd1; logic [2:0] m1;
    logic iv2, ir2, neg2, ov2; logic [7:0]  bcd2; logic [1:0] m2;
    logic iv3, ir3, neg3, ov3; logic [39:0] bcd3; logic [9:0] m3;

    assign iv0 = iv_all && (sel == 0);
    assign iv1 = iv_all && (sel == 1);
    assign iv2 = iv_all && (sel == 2);
    assign iv3 = iv_all && (sel == 3);

    binario_para_bcd_seq #(.LARGURA(16), .DIGITOS(5), .SINAL(1'b0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .binario(bin_all[15:0]), .in_valid(iv0), .in_ready(ir0),
        .bcd(bcd0), .negativo(neg0), .mascara(m0), .out_valid(ov0), .out_ready(or_all)
    );
    binario_para_bcd_seq #(.LARGURA(8), .DIGITOS(3), .SINAL(1'b1)) u_dut8s (
        .clk(clk), .rst_n(rst_n), .binario(bin_all[7:0]), .in_valid(iv1), .in_ready(ir1),
        .bcd(bcd1), .negativo(neg1), .mascara(m1), .out_valid(ov1), .out_ready(or_all)
    );
    binario_para_bcd_seq #(.LARGURA(4), .DIGITOS(2), .SINAL(1'b0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .binario(bin_all[3:0]), .in_valid(iv2), .in_ready(ir2),
        .bcd(bcd2), .negativo(neg2), .mascara(m2), .out_valid(ov2), .out_ready(or_all)
    );
    binario_para_bcd_seq #(.LARGURA(32), .DIGITOS(10), .SINAL(1'b0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .binario(bin_all), .in_valid(iv3), .in_ready(ir3),
        .bcd(bcd3), .negativo(neg3), .mascara(m3), .out_valid(ov3), .out_ready(or_all)
    );

    logic [39:0] v_bcd;
    logic [9:0]  v_mask;
    logic        v_neg, v_ov, v_ir;

    always_comb begin
        v_bcd  = '0;
        v_mask = '0;
        v_neg  = 1'b0;
        v_ov   = 1'b0;
        v_ir   = 1'b0;
        case (sel)
            0: begin v_bcd = 40'(bcd0); v_mask = 10'(m0); v_neg = neg0; v_ov = ov0; v_ir = ir0; end
            1: begin v_bcd = 40'(bcd1); v_mask = 10'(m1); v_neg = neg1; v_ov = ov1; v_ir = ir1; end
            2: begin v_bcd = 40'(bcd2); v_mask = 10'(m2); v_neg = neg2; v_ov = ov2; v_ir = ir2; end
            3: begin v_bcd = bcd3;      v_mask = m3;      v_neg = neg3; v_ov = ov3; v_ir = ir3; end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain decimal conversion of the operand's magnitude.
    function automatic void modelo(input int s, input logic [31:0] val,
                                   output logic [39:0] e_bcd, output logic e_neg,
                                   output logic [9:0] e_mask);
        longint unsigned cru, mag, lim;
        lim   = 64'd1 << larg[s];
        cru   = {32'd0, val} % lim;
        mag   = cru;
        e_neg = 1'b0;
        if (sin[s] && (cru >= lim / 2)) begin
            mag   = lim - cru;
            e_neg = 1'b1;
        end
        e_bcd = '0;
        for (int k = 0; k < dig[s]; k++) begin
            e_bcd[4*k +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e_mask = '0;
        for (int k = 0; k < dig[s]; k++) e_mask[k] = (k == 0) || ((e_bcd >> (4 * k)) != 40'd0);
    endfunction

    task automatic iniciar(input int s, input logic [31:0] val);
        int espera;
        espera = 0;
        sel    = s;
        #1;
        while (!v_ir && espera < 50) begin
            @(posedge clk); #1;
            espera++;
        end
        check_eq("in_ready_before_accept", 64'(v_ir), 64'd1);
        @(negedge clk);
        bin_all = val;
        iv_all  = 1'b1;
        @(posedge clk); #1;
        iv_all  = 1'b0;
    endtask

    task automatic aguardar(input int s, output int lat);
        lat = 0;
        while (!v_ov && lat < larg[s] + 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consumir();
        @(negedge clk);
        or_all = 1'b1;
        @(posedge clk); #1;
        or_all = 1'b0;
    endtask

    task automatic dirigido(input int s, input logic [31:0] val, input logic [39:0] e_bcd,
                            input logic e_neg, input logic [9:0] e_mask, input string tag);
        int lat;
        iniciar(s, val);
        aguardar(s, lat);
        check_eq({tag, "_latency"}, 64'(lat), 64'(larg[s]));
        check_eq({tag, "_bcd"}, 64'(v_bcd), 64'(e_bcd));
        check_eq({tag, "_neg"}, 64'(v_neg), 64'(e_neg));
        check_eq({tag, "_mask"}, 64'(v_mask), 64'(e_mask));
        consumir();
        check_eq({tag, "_out_valid_drop"}, 64'(v_ov), 64'd0);
    endtask

    task automatic aleatorio(input int s, input logic [31:0] val);
        logic [39:0] eb;
        logic        en;
        logic [9:0]  em;
        int          lat;
        modelo(s, val, eb, en, em);
        iniciar(s, val);
        aguardar(s, lat);
        check_eq("rand_latency", 64'(lat), 64'(larg[s]));
        check_eq("rand_bcd", 64'(v_bcd), 64'(eb));
        check_eq("rand_neg", 64'(v_neg), 64'(en));
        check_eq("rand_mask", 64'(v_mask), 64'(em));
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        check_eq("rand_hold_bcd", 64'(v_bcd), 64'(eb));
        consumir();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n   = 1'b0;
        bin_all = '0;
        iv_all  = 1'b0;
        or_all  = 1'b0;
        sel     = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(ir0), 64'd0);
        check_eq("rst_out_valid", 64'(ov0), 64'd0);
        check_eq("rst_bcd", 64'(bcd0), 64'd0);
        check_eq("rst_neg", 64'(neg0), 64'd0);
        check_eq("rst_mask", 64'(m0), 64'd1);
        check_eq("rst_mask_8s", 64'(m1), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready_after", 64'(ir0), 64'd1);

        // Directed values
        dirigido(0, 32'd65535, 40'h65535, 1'b0, 10'b11111, "u16_65535");
        dirigido(0, 32'd0,     40'h00000, 1'b0, 10'b00001, "u16_zero");
        dirigido(1, 32'h80,    40'h128,   1'b1, 10'b111,   "s8_min");
        dirigido(1, 32'h7F,    40'h127,   1'b0, 10'b111,   "s8_max");
        dirigido(1, 32'hFF,    40'h001,   1'b1, 10'b001,   "s8_minus1");
        dirigido(2, 32'd15,    40'h15,    1'b0, 10'b11,    "u4_max");
        dirigido(3, 32'hFFFF_FFFF, 40'h42_9496_7295, 1'b0, 10'h3FF, "u32_max");

        // Back-pressure: result held while a competing operand is offered
        iniciar(0, 32'd1234);
        aguardar(0, lat);
        check_eq("bp_latency", 64'(lat), 64'd16);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bin_all = 32'd999;
            iv_all  = 1'b1;
            @(posedge clk); #1;
            check_eq("bp_bcd", 64'(bcd0), 64'h01234);
            check_eq("bp_mask", 64'(m0), 64'b01111);
            check_eq("bp_out_valid", 64'(ov0), 64'd1);
            check_eq("bp_in_ready", 64'(ir0), 64'd0);
        end
        @(negedge clk);
        iv_all = 1'b0;
        consumir();
        repeat (20) @(posedge clk);
        #1;
        check_eq("bp_no_accept_ov", 64'(ov0), 64'd0);
        check_eq("bp_no_accept_bcd", 64'(bcd0), 64'h01234);
        check_eq("bp_idle_in_ready", 64'(ir0), 64'd1);

        // Reset in the middle of a conversion
        iniciar(0, 32'd65535);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_in_ready", 64'(ir0), 64'd0);
        check_eq("midrst_out_valid", 64'(ov0), 64'd0);
        check_eq("midrst_bcd", 64'(bcd0), 64'd0);
        check_eq("midrst_mask", 64'(m0), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("midrst_no_partial", 64'(ov0), 64'd0);
        dirigido(0, 32'd42, 40'h00042, 1'b0, 10'b00011, "after_rst_42");

        // Random sweeps against the decimal model
        for (int i = 0; i < 300; i++) aleatorio(2, $urandom());
        for (int i = 0; i < 400; i++) aleatorio(0, $urandom());
        for (int i = 0; i < 200; i++) aleatorio(1, $urandom());
        for (int i = 0; i < 250; i++) aleatorio(3, $urandom());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
